// File: rtl/regfile_port_arbiter_if.sv
// Request, regfile-port and response bundle between requesters, the port arbiter and the dual-port regfile.
// The master side is the requesters plus regfile read data; the slave side is the arbiter.
interface regfile_port_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int RAM_A_WIDTH = 10,
  parameter int RAM_D_WIDTH = 8
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_we;
  logic [N_REQ*RAM_A_WIDTH-1:0] req_addr;
  logic [N_REQ*RAM_D_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]             req_ready;

  logic [RAM_A_WIDTH-1:0]       rf_addr_a, rf_addr_b;
  logic [RAM_D_WIDTH-1:0]       rf_din_a, rf_din_b;
  logic                         rf_we_a, rf_we_b;
  logic [RAM_D_WIDTH-1:0]       rf_dout_a, rf_dout_b;

  logic                         rsp_a_valid, rsp_b_valid;
  logic [ID_W-1:0]              rsp_a_id, rsp_b_id;
  logic [RAM_D_WIDTH-1:0]       rsp_a_data, rsp_b_data;
  logic [15:0]                  conflict_cnt;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rf_dout_a, rf_dout_b,
    input  req_ready, rf_addr_a, rf_din_a, rf_we_a, rf_addr_b, rf_din_b, rf_we_b,
    input  rsp_a_valid, rsp_a_id, rsp_a_data, rsp_b_valid, rsp_b_id, rsp_b_data, conflict_cnt
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rf_dout_a, rf_dout_b,
    output req_ready, rf_addr_a, rf_din_a, rf_we_a, rf_addr_b, rf_din_b, rf_we_b,
    output rsp_a_valid, rsp_a_id, rsp_a_data, rsp_b_valid, rsp_b_id, rsp_b_data, conflict_cnt
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing both regfile ports among N_REQ requesters: grant same cycle, regfile
// signals registered one cycle later, tagged read data two cycles after grant; responses never stall.
module regfile_port_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int RAM_SIZE    = 1024,
  parameter int RAM_A_WIDTH = 10,
  parameter int RAM_D_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  regfile_port_arbiter_if.slave arb
);
  localparam int AW = RAM_A_WIDTH;
  localparam int DW = RAM_D_WIDTH;

  logic [AW-1:0]    req_addr  [N_REQ];
  logic [DW-1:0]    req_wdata [N_REQ];
  logic [DW-1:0]    rf_dout   [2];

  logic             gnt  [2];
  logic [ID_W-1:0]  gidx [2];
  logic [ID_W-1:0]  scan;
  logic             conflict_skip;
  logic [N_REQ-1:0] ready;

  logic [ID_W-1:0]  rr_q, rr_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [AW-1:0]    rf_addr_q [2], rf_addr_d [2];
  logic [DW-1:0]    rf_din_q  [2], rf_din_d  [2];
  logic             rf_we_q   [2], rf_we_d   [2];
  logic             s1_rd_q   [2], s1_rd_d   [2];
  logic             s1_oor_q  [2], s1_oor_d  [2];
  logic [ID_W-1:0]  s1_id_q   [2], s1_id_d   [2];
  logic             rsp_vld_q [2], rsp_vld_d [2];
  logic [ID_W-1:0]  rsp_id_q  [2], rsp_id_d  [2];
  logic [DW-1:0]    rsp_dat_q [2], rsp_dat_d [2];

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    return ID_W'((int'(base) + k) % N_REQ);
  endfunction

  // Two reads of one address may share a cycle; anything involving a write may not.
  function automatic logic conflicts(input logic [AW-1:0] a0, input logic w0,
                                     input logic [AW-1:0] a1, input logic w1);
    return (a0 == a1) && (w0 || w1);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i]  = arb.req_addr[i*AW +: AW];
      req_wdata[i] = arb.req_wdata[i*DW +: DW];
    end
    rf_dout[0] = arb.rf_dout_a;
    rf_dout[1] = arb.rf_dout_b;
  end

  always_comb begin
    gnt[0]        = 1'b0;
    gnt[1]        = 1'b0;
    gidx[0]       = '0;
    gidx[1]       = '0;
    scan          = '0;
    conflict_skip = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = wrap_add(rr_q, k);
      if (arb.req_valid[scan]) begin
        if (!gnt[0]) begin
          gnt[0]  = 1'b1;
          gidx[0] = scan;
        end else if (!gnt[1]) begin
          if (conflicts(req_addr[gidx[0]], arb.req_we[gidx[0]], req_addr[scan], arb.req_we[scan])) begin
            conflict_skip = 1'b1;
          end else begin
            gnt[1]  = 1'b1;
            gidx[1] = scan;
          end
        end
      end
    end
  end

  // Port B is scanned after port A, so its grant (when present) sets the next pointer.
  always_comb begin
    ready = '0;
    rr_d  = rr_q;
    for (int p = 0; p < 2; p++) begin
      if (gnt[p]) begin
        ready[gidx[p]] = 1'b1;
        rr_d           = wrap_add(gidx[p], 1);
      end
      rf_addr_d[p] = gnt[p] ? req_addr[gidx[p]] : '0;
      rf_we_d[p]   = gnt[p] && arb.req_we[gidx[p]];
      rf_din_d[p]  = rf_we_d[p] ? req_wdata[gidx[p]] : '0;
      s1_rd_d[p]   = gnt[p] && !arb.req_we[gidx[p]];
      s1_id_d[p]   = gnt[p] ? gidx[p] : '0;
      s1_oor_d[p]  = 32'(rf_addr_d[p]) >= RAM_SIZE;
      rsp_vld_d[p] = s1_rd_q[p];
      rsp_id_d[p]  = s1_rd_q[p] ? s1_id_q[p] : '0;
      rsp_dat_d[p] = (s1_rd_q[p] && !s1_oor_q[p]) ? rf_dout[p] : '0;
    end
    cnt_d = (conflict_skip && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      cnt_q <= '0;
      for (int p = 0; p < 2; p++) begin
        rf_addr_q[p] <= '0;
        rf_din_q[p]  <= '0;
        rf_we_q[p]   <= 1'b0;
        s1_rd_q[p]   <= 1'b0;
        s1_oor_q[p]  <= 1'b0;
        s1_id_q[p]   <= '0;
        rsp_vld_q[p] <= 1'b0;
        rsp_id_q[p]  <= '0;
        rsp_dat_q[p] <= '0;
      end
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      for (int p = 0; p < 2; p++) begin
        rf_addr_q[p] <= rf_addr_d[p];
        rf_din_q[p]  <= rf_din_d[p];
        rf_we_q[p]   <= rf_we_d[p];
        s1_rd_q[p]   <= s1_rd_d[p];
        s1_oor_q[p]  <= s1_oor_d[p];
        s1_id_q[p]   <= s1_id_d[p];
        rsp_vld_q[p] <= rsp_vld_d[p];
        rsp_id_q[p]  <= rsp_id_d[p];
        rsp_dat_q[p] <= rsp_dat_d[p];
      end
    end
  end

  assign arb.req_ready    = rst ? '0 : ready;
  assign arb.rf_addr_a    = rf_addr_q[0];
  assign arb.rf_din_a     = rf_din_q[0];
  assign arb.rf_we_a      = rf_we_q[0];
  assign arb.rf_addr_b    = rf_addr_q[1];
  assign arb.rf_din_b     = rf_din_q[1];
  assign arb.rf_we_b      = rf_we_q[1];
  assign arb.rsp_a_valid  = rsp_vld_q[0];
  assign arb.rsp_a_id     = rsp_id_q[0];
  assign arb.rsp_a_data   = rsp_dat_q[0];
  assign arb.rsp_b_valid  = rsp_vld_q[1];
  assign arb.rsp_b_id     = rsp_id_q[1];
  assign arb.rsp_b_data   = rsp_dat_q[1];
  assign arb.conflict_cnt = cnt_q;
endmodule
